conv3x3_stream: RTL and testbench
=================================

# conv3x3_stream

Streaming 3x3 convolution engine; successor to the fixed 9-pixel block-buffer convolver. Accepts one grayscale pixel per valid cycle in raster order, keeps two line buffers of IMG_W pixels, and forms a sliding 3x3 window. Applies a per-frame-selectable kernel: Gaussian, Sobel X magnitude, Sobel Y magnitude or passthrough. Sits between the grayscale front end and the gradient strength/direction stages.

## Interface
- PIX_W, 8, pixel bit width (input and output)
- IMG_W, 512, pixels per line; 3 ≤ IMG_W ≤ 4096
- IMG_H, 512, lines per frame; 3 ≤ IMG_H ≤ 4096
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- mode  in  2  kernel select: 0 Gaussian, 1 Sobel X, 2 Sobel Y, 3 passthrough; sampled only with a frame-start pixel
- in_valid  in  1  in_pixel/in_sof valid this cycle; no backpressure, block always accepts
- in_sof  in  1  with in_valid: this pixel is (row 0, col 0)
- in_pixel  in  PIX_W  grayscale pixel
- out_valid  out  1  out_pixel valid, one-cycle pulse per result
- out_pixel  out  PIX_W  filtered pixel
- out_last  out  1  high with out_valid on the final output of a frame

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel. col wraps to 0 and increments row; after (IMG_W-1, IMG_H-1), wraps to (0,0) without needing in_sof.
- in_sof with in_valid forces that pixel to (0,0) regardless of counters, and latches mode into mode_q. mode changes at any other time are ignored.
- Line buffers: two IMG_W×PIX_W memories, written at index col with the current pixel and the previous line. Each has one read and one write per accepted pixel. Window shift registers (3×3) shift only on accepted pixels.
- A window is complete when the accepted pixel has row ≥ 2 and col ≥ 2. Its result is for centre (row-1, col-1). Only interior pixels produce output: (IMG_W-2)×(IMG_H-2) results per frame, no border padding.
- Window is p[r][c], r,c ∈ {0,1,2}; row 0 is oldest; p[2][2] is the newest pixel.
- Gaussian: sum of p weighted [1 2 1; 2 4 2; 1 2 1], then >>4 (truncate). The intermediate is PIX_W+4 bits unsigned, and the result never exceeds 2^PIX_W-1.
- Sobel X: gx = (p02+2p12+p22) − (p00+2p10+p20). Sobel Y: gy = (p20+2p21+p22) − (p00+2p01+p02). Both are signed PIX_W+4 bits. Output is |g| saturated to 2^PIX_W-1.
- Passthrough: output p[1][1].
- out_last asserts for the result at centre (IMG_H-2, IMG_W-2).

## Timing
- Reset values: out_valid=0, out_pixel=0, out_last=0, col=0, row=0, mode_q=0, window registers=0. Line buffer contents are not reset; they are never used before refill.
- Latency: completing pixel accepted at edge N → out_valid, out_pixel, out_last registered at edge N+2. Stage 1 is the multiply-add; stage 2 is abs/saturate/shift.
- Pipeline advances every cycle regardless of in_valid; each accepted window yields exactly one out_valid pulse. in_valid gaps delay outputs one-for-one.
- Back-to-back valid: one result per cycle sustained on interior pixels.
- in_sof mid-frame: counters restart at (0,0) at that edge. Results already in the pipeline still emit, using the old mode_q. No window spanning the sof is completed, because row < 2 after restart.
- in_sof without in_valid: ignored.
- reset asserted mid-frame: pipeline results in flight are discarded and out_valid drops immediately (async). After release, the first pixel is (0,0) with or without in_sof.
- Simultaneous sof and row/col wrap: sof takes priority, with the same result (0,0).

## Test plan
- IMG_W=IMG_H=8, mode 0, constant 100 frame → 36 outputs all 100; out_last only on the 36th; first out_valid 2 cycles after pixel (2,2).
- Mode 1, pixel = col×10 → every output 80. Mode 2 on same frame → every output 0.
- Mode 1, cols 0–3 = 0, cols 4–7 = 200 → centre cols 3 and 4 give 255 (saturated from 800), all others 0.
- Mode change to 1 at mid-frame pixel (4,0) without sof, frame started in mode 3 → all 36 outputs equal the centre pixels; next sof with mode 1 takes effect.
- Random in_valid gaps (50% duty), mode 0, random pixels → output stream matches the reference model bit-exact, count 36 per frame, frames back-to-back with no sof after the first.
- reset pulse at pixel (5,3), then a new frame → no outputs from the aborted frame after reset; new frame yields exactly 36 correct results.

Source files
------------

// File: rtl/conv3x3_stream_if.sv
// rtl/conv3x3_stream_if.sv - pixel stream in/out bundle for the 3x3 convolution engine
interface conv3x3_stream_if #(
  parameter int PIX_W = 8
);
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic [PIX_W-1:0] out_pixel;
  logic             out_last;

  modport master (
    output mode, in_valid, in_sof, in_pixel,
    input  out_valid, out_pixel, out_last
  );

  modport slave (
    input  mode, in_valid, in_sof, in_pixel,
    output out_valid, out_pixel, out_last
  );
endinterface

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 convolver: two line buffers, sliding window, 2-stage kernel pipe
module conv3x3_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input logic             clk,
  input logic             reset,
  conv3x3_stream_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = PIX_W + 4;
  localparam logic [CW-1:0]    COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_MAX = RW'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;
  localparam logic [1:0] M_GAUSS = 2'd0;
  localparam logic [1:0] M_SOBX  = 2'd1;
  localparam logic [1:0] M_SOBY  = 2'd2;

  logic [CW-1:0] col, pos_col;
  logic [RW-1:0] row, pos_row;
  logic [1:0]    mode_q;
  logic          accept, sof, complete, at_last;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic [PIX_W-1:0] win [3][3];
  logic             win_valid, win_last;
  logic [1:0]       win_mode;

  logic [SW-1:0] e [3][3];
  logic [SW-1:0] gsum, gx, gy, s1_next;
  logic          s1_valid, s1_last;
  logic [1:0]    s1_mode;
  logic [SW-1:0] s1_val, mag;
  logic [PIX_W-1:0] sat, s2_pix;

  assign accept = bus.in_valid;
  assign sof    = bus.in_valid & bus.in_sof;

  // A frame-start pixel is placed at (0,0) whatever the counters say.
  always_comb begin
    pos_col = sof ? '0 : col;
    pos_row = sof ? '0 : row;
  end

  assign complete = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
  assign at_last  = (pos_row == ROW_MAX) && (pos_col == COL_MAX);

  assign lb0_rd = lb0[pos_col];
  assign lb1_rd = lb1[pos_col];

  // Line buffers hold only image data and are never read before being refilled.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[pos_col] <= bus.in_pixel;
      lb1[pos_col] <= lb0_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_mode  <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      win_valid <= complete;
      win_last  <= complete && at_last;
      win_mode  <= mode_q;
      if (accept) begin
        if (pos_col == COL_MAX) begin
          col <= '0;
          row <= (pos_row == ROW_MAX) ? '0 : pos_row + 1'b1;
        end else begin
          col <= pos_col + 1'b1;
          row <= pos_row;
        end
        if (sof)
          mode_q <= bus.mode;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= bus.in_pixel;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e[r][c] = SW'(win[r][c]);
  end

  // Sobel terms wrap modulo 2^SW; the true range always fits as two's complement.
  always_comb begin
    gsum = e[0][0] + (e[0][1] << 1) + e[0][2]
         + (e[1][0] << 1) + (e[1][1] << 2) + (e[1][2] << 1)
         + e[2][0] + (e[2][1] << 1) + e[2][2];
    gx = (e[0][2] + (e[1][2] << 1) + e[2][2]) - (e[0][0] + (e[1][0] << 1) + e[2][0]);
    gy = (e[2][0] + (e[2][1] << 1) + e[2][2]) - (e[0][0] + (e[0][1] << 1) + e[0][2]);
    case (win_mode)
      M_GAUSS: s1_next = gsum;
      M_SOBX:  s1_next = gx;
      M_SOBY:  s1_next = gy;
      default: s1_next = e[1][1];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= '0;
      s1_val   <= '0;
    end else begin
      s1_valid <= win_valid;
      s1_last  <= win_last;
      s1_mode  <= win_mode;
      s1_val   <= s1_next;
    end
  end

  always_comb begin
    mag = s1_val[SW-1] ? (~s1_val + SW'(1)) : s1_val;
    sat = (mag > {4'b0, PIX_MAX}) ? PIX_MAX : mag[PIX_W-1:0];
    case (s1_mode)
      M_GAUSS:        s2_pix = s1_val[PIX_W+3:4];
      M_SOBX, M_SOBY: s2_pix = sat;
      default:        s2_pix = s1_val[PIX_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_pixel <= '0;
    end else begin
      bus.out_valid <= s1_valid;
      bus.out_last  <= s1_last;
      bus.out_pixel <= s2_pix;
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - self-checking bench for conv3x3_stream against a per-pixel reference model
module tb_conv3x3_stream;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv3x3_stream_if #(.PIX_W(PW)) bus ();

  conv3x3_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int pix;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int img [H][W];
  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  int cyc      = 0;
  int t22      = -1;
  int t_first  = -1;

  function automatic int ref_px(int m, int r, int c);
    int g, s;
    case (m)
      0: s = (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]
            + 2*img[r][c-1] + 4*img[r][c]   + 2*img[r][c+1]
            + img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1]) / 16;
      1: begin
        g = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
          - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        s = (g < 0) ? -g : g;
        if (s > 255) s = 255;
      end
      2: begin
        g = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
          - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        s = (g < 0) ? -g : g;
        if (s > 255) s = 255;
      end
      default: s = img[r][c];
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (t_first < 0) t_first = cyc;
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_pixel", 32'(bus.out_pixel), 32'(e.pix));
        check("out_last", 32'(bus.out_last), 32'(e.last));
      end
    end else begin
      check("idle_last", 32'(bus.out_last), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'($urandom_range(0, 1));
      bus.in_pixel = 8'($urandom);
      tick();
    end
  endtask

  task automatic push_frame(input int m);
    for (int r = 1; r <= H-2; r++)
      for (int c = 1; c <= W-2; c++)
        exp_q.push_back('{ref_px(m, r, c), (r == H-2) && (c == W-2)});
  endtask

  task automatic send_frame(input int m_ref, input int sof_mode, input bit use_sof,
                            input int other_mode, input bit gaps,
                            input int abort_r, input int abort_c);
    bit first;
    push_frame(m_ref);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == abort_r && c == abort_c) return;
        if (gaps)
          while ($urandom_range(0, 1) == 1) idle(1);
        first        = use_sof && (r == 0) && (c == 0);
        bus.in_valid = 1'b1;
        bus.in_sof   = first;
        bus.mode     = first ? 2'(sof_mode)
                     : (other_mode < 0 ? 2'($urandom_range(0, 3)) : 2'(other_mode));
        bus.in_pixel = 8'(img[r][c]);
        tick();
        if (r == 2 && c == 2) t22 = cyc;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = c * 10;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.mode     = 2'd0;
    bus.in_pixel = '0;
    repeat (3) tick();
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_pixel", 32'(bus.out_pixel), 32'd0);
    check("reset_out_last", 32'(bus.out_last), 32'd0);
    reset = 1'b0;
    tick();

    // Constant frame, Gaussian: latency and out_last position.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 100;
    n_out = 0; t_first = -1;
    send_frame(0, 0, 1, -1, 0, -1, -1);
    idle(4);
    check("latency", 32'(t_first - t22), 32'd2);
    check("count_const", 32'(n_out), 32'd36);
    check("drained_const", 32'(exp_q.size()), 32'd0);

    // Horizontal ramp: Sobel X constant 80, Sobel Y zero.
    fill_ramp();
    n_out = 0;
    send_frame(1, 1, 1, -1, 0, -1, -1);
    send_frame(2, 2, 1, -1, 0, -1, -1);
    idle(4);
    check("count_ramp", 32'(n_out), 32'd72);
    check("drained_ramp", 32'(exp_q.size()), 32'd0);

    // Vertical step: saturating Sobel X.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (c < 4) ? 0 : 200;
    n_out = 0;
    send_frame(1, 1, 1, -1, 0, -1, -1);
    idle(4);
    check("count_step", 32'(n_out), 32'd36);

    // Mode input changes without sof are ignored until the next frame start.
    fill_rand();
    n_out = 0;
    send_frame(3, 3, 1, 1, 0, -1, -1);
    fill_ramp();
    send_frame(1, 1, 1, 0, 0, -1, -1);
    idle(4);
    check("count_modechg", 32'(n_out), 32'd72);
    check("drained_modechg", 32'(exp_q.size()), 32'd0);

    // Random gaps, back-to-back frames, only the first carries sof.
    n_out = 0;
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      send_frame(0, 0, (f == 0), -1, 1, -1, -1);
    end
    idle(4);
    check("count_gaps", 32'(n_out), 32'd108);
    check("drained_gaps", 32'(exp_q.size()), 32'd0);

    // Abort mid-frame with reset, then a frame without sof uses the reset mode.
    fill_rand();
    send_frame(0, 0, 1, -1, 0, 5, 3);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    idle(3);
    fill_rand();
    n_out = 0;
    send_frame(0, 0, 0, 2, 0, -1, -1);
    idle(4);
    check("count_after_reset", 32'(n_out), 32'd36);
    check("drained_after_reset", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
